// File: rtl/led_pattern_checker_if.sv
// Bus between the LED pattern generator side and the pattern checker.
// The generator side drives the strobe and the byte; the checker drives status.
interface led_pattern_checker_if;
   logic       ss;
   logic [7:0] led_in;
   logic       locked;
   logic [1:0] mode_out;
   logic [2:0] step;
   logic       frame_done;
   logic       mode_chg;
   logic       err;
   logic [7:0] err_cnt;
   logic [7:0] frame_cnt;

   modport master (
      output ss, led_in,
      input  locked, mode_out, step, frame_done, mode_chg, err, err_cnt, frame_cnt
   );

   modport slave (
      input  ss, led_in,
      output locked, mode_out, step, frame_done, mode_chg, err, err_cnt, frame_cnt
   );
endinterface

// File: rtl/led_pattern_checker.sv
// Receive-side monitor for the 8-bit LED step-pattern bus. Identifies the
// running pattern, tracks step position, and reports frames, switches and
// illegal bytes. All outputs are registered.
module led_pattern_checker (
   input  logic                   clk,
   input  logic                   reset,
   led_pattern_checker_if.slave   bus
);

   typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} state_t;

   // Byte at position idx of the frame for mode m.
   function automatic logic [7:0] pat(input logic [1:0] m, input logic [2:0] idx);
      logic [7:0] b;
      case (m)
         2'b00:   b = 8'hFF >> (3'd7 - idx);
         2'b01:   b = 8'hFF << (3'd7 - idx);
         2'b10: begin
            case (idx[1:0])
               2'd0:    b = 8'h18;
               2'd1:    b = 8'h3C;
               2'd2:    b = 8'h7E;
               default: b = 8'hFF;
            endcase
         end
         default: begin
            case (idx[1:0])
               2'd0:    b = 8'h81;
               2'd1:    b = 8'hC3;
               2'd2:    b = 8'hE7;
               default: b = 8'hFF;
            endcase
         end
      endcase
      return b;
   endfunction

   // Index of the final (FF) byte in a frame of mode m.
   function automatic logic [2:0] last_step(input logic [1:0] m);
      return m[1] ? 3'd3 : 3'd7;
   endfunction

   state_t     state_q, state_d;
   logic [1:0] mode_q, mode_d;
   logic [2:0] step_q, step_d;
   logic       frame_done_q, frame_done_d;
   logic       mode_chg_q, mode_chg_d;
   logic       err_q, err_d;
   logic [7:0] err_cnt_q, err_cnt_d;
   logic [7:0] frame_cnt_q, frame_cnt_d;

   logic       uniq;
   logic [1:0] u_mode;
   logic [2:0] u_idx;
   logic [2:0] nxt_step;
   logic [7:0] exp_byte;

   // Classify the incoming byte: which mode/index it uniquely belongs to.
   // FF is shared by every mode, so it never counts as unique.
   always_comb begin
      uniq   = 1'b0;
      u_mode = 2'b00;
      u_idx  = 3'd0;
      for (int m = 0; m < 4; m++) begin
         for (int i = 0; i < 8; i++) begin
            if ((3'(i) <= last_step(2'(m))) && (pat(2'(m), 3'(i)) == bus.led_in)
                && (bus.led_in != 8'hFF)) begin
               uniq   = 1'b1;
               u_mode = 2'(m);
               u_idx  = 3'(i);
            end
         end
      end
   end

   // Expected next byte while locked: wrap to step 0 after the final byte.
   always_comb begin
      nxt_step = (step_q == last_step(mode_q)) ? 3'd0 : step_q + 3'd1;
      exp_byte = pat(mode_q, nxt_step);
   end

   // Next-state and registered-output computation for each strobe sample.
   always_comb begin
      state_d      = state_q;
      mode_d       = mode_q;
      step_d       = step_q;
      frame_done_d = 1'b0;
      mode_chg_d   = 1'b0;
      err_d        = 1'b0;
      err_cnt_d    = err_cnt_q;
      frame_cnt_d  = frame_cnt_q;
      if (bus.ss) begin
         case (state_q)
            UNLOCKED: begin
               if (uniq) begin
                  state_d = LOCKED;
                  mode_d  = u_mode;
                  step_d  = u_idx;
               end
            end
            default: begin
               if (bus.led_in == exp_byte) begin
                  step_d = nxt_step;
                  if (bus.led_in == 8'hFF) begin
                     frame_done_d = 1'b1;
                     frame_cnt_d  = frame_cnt_q + 8'd1;
                  end
               end else if (uniq && (u_idx == 3'd0) && (u_mode != mode_q)) begin
                  mode_d     = u_mode;
                  step_d     = 3'd0;
                  mode_chg_d = 1'b1;
               end else begin
                  err_d = 1'b1;
                  if (err_cnt_q != 8'hFF)
                     err_cnt_d = err_cnt_q + 8'd1;
                  if (uniq) begin
                     mode_d = u_mode;
                     step_d = u_idx;
                  end else begin
                     state_d = UNLOCKED;
                  end
               end
            end
         endcase
      end
   end

   // State and output registers; reset clears everything immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= UNLOCKED;
         mode_q       <= 2'b00;
         step_q       <= 3'd0;
         frame_done_q <= 1'b0;
         mode_chg_q   <= 1'b0;
         err_q        <= 1'b0;
         err_cnt_q    <= 8'h00;
         frame_cnt_q  <= 8'h00;
      end else begin
         state_q      <= state_d;
         mode_q       <= mode_d;
         step_q       <= step_d;
         frame_done_q <= frame_done_d;
         mode_chg_q   <= mode_chg_d;
         err_q        <= err_d;
         err_cnt_q    <= err_cnt_d;
         frame_cnt_q  <= frame_cnt_d;
      end
   end

   assign bus.locked     = (state_q == LOCKED);
   assign bus.mode_out   = mode_q;
   assign bus.step       = step_q;
   assign bus.frame_done = frame_done_q;
   assign bus.mode_chg   = mode_chg_q;
   assign bus.err        = err_q;
   assign bus.err_cnt    = err_cnt_q;
   assign bus.frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_led_pattern_checker.sv
// Directed self-checking bench for led_pattern_checker.
module tb_led_pattern_checker;

   logic clk;
   logic reset;
   int   checks;
   int   fails;

   led_pattern_checker_if bus();

   led_pattern_checker dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic apply_reset();
      reset      = 1'b1;
      bus.ss     = 1'b0;
      bus.led_in = 8'h00;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Present one byte with ss high for one cycle; sample 1ns after the edge.
   task automatic do_ss(input logic [7:0] b);
      @(negedge clk);
      bus.ss     = 1'b1;
      bus.led_in = b;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      @(negedge clk);
      bus.ss = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset();
      #1;
      checks++;
      if ({bus.locked, bus.mode_out, bus.step, bus.frame_done, bus.mode_chg, bus.err} !== 9'd0) begin
         fails++;
         $display("FAIL reset_flags got locked=%b mode=%0d step=%0d fd=%b mc=%b err=%b want all 0",
                  bus.locked, bus.mode_out, bus.step, bus.frame_done, bus.mode_chg, bus.err);
      end
      checks++;
      if (bus.err_cnt !== 8'h00 || bus.frame_cnt !== 8'h00) begin
         fails++;
         $display("FAIL reset_counts got err_cnt=%h frame_cnt=%h want 00/00", bus.err_cnt, bus.frame_cnt);
      end
   endtask

   task automatic test_fill_left();
      logic [7:0] seq [9] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h01};
      logic [2:0] es  [9] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
      apply_reset();
      for (int i = 0; i < 9; i++) begin
         do_ss(seq[i]);
         checks++;
         if (bus.locked !== 1'b1 || bus.step !== es[i] || bus.mode_out !== 2'b00) begin
            fails++;
            $display("FAIL fill_state i=%0d got locked=%b step=%0d mode=%0d want 1/%0d/0",
                     i, bus.locked, bus.step, bus.mode_out, es[i]);
         end
         checks++;
         if (bus.frame_done !== 1'(i == 7) || bus.err !== 1'b0 || bus.mode_chg !== 1'b0) begin
            fails++;
            $display("FAIL fill_pulses i=%0d got fd=%b err=%b mc=%b want fd=%b err=0 mc=0",
                     i, bus.frame_done, bus.err, bus.mode_chg, 1'(i == 7));
         end
      end
      idle();
      checks++;
      if (bus.frame_cnt !== 8'h01 || bus.err_cnt !== 8'h00) begin
         fails++;
         $display("FAIL fill_counts got frame_cnt=%h err_cnt=%h want 01/00", bus.frame_cnt, bus.err_cnt);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] seq [6] = '{8'h18, 8'h3C, 8'h7E, 8'hFF, 8'h18, 8'h81};
      logic [2:0] es  [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd0};
      logic [1:0] em  [6] = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd3};
      int fd_seen;
      fd_seen = 0;
      apply_reset();
      for (int i = 0; i < 6; i++) begin
         do_ss(seq[i]);
         if (bus.frame_done === 1'b1) fd_seen++;
         checks++;
         if (bus.step !== es[i] || bus.mode_out !== em[i] || bus.locked !== 1'b1) begin
            fails++;
            $display("FAIL conv_state i=%0d got step=%0d mode=%0d locked=%b want %0d/%0d/1",
                     i, bus.step, bus.mode_out, bus.locked, es[i], em[i]);
         end
         checks++;
         if (bus.mode_chg !== 1'(i == 5) || bus.err !== 1'b0) begin
            fails++;
            $display("FAIL conv_pulses i=%0d got mc=%b err=%b want mc=%b err=0",
                     i, bus.mode_chg, bus.err, 1'(i == 5));
         end
      end
      idle();
      checks++;
      if (fd_seen != 1 || bus.frame_cnt !== 8'h01) begin
         fails++;
         $display("FAIL conv_frames got fd_pulses=%0d frame_cnt=%h want 1/01", fd_seen, bus.frame_cnt);
      end
   endtask

   task automatic test_skip();
      apply_reset();
      do_ss(8'h80);
      do_ss(8'hC0);
      do_ss(8'hE0);
      do_ss(8'hF8);
      checks++;
      if (bus.err !== 1'b1 || bus.err_cnt !== 8'h01 || bus.locked !== 1'b1 ||
          bus.mode_out !== 2'b01 || bus.step !== 3'd4) begin
         fails++;
         $display("FAIL skip_relock got err=%b err_cnt=%h locked=%b mode=%0d step=%0d want 1/01/1/1/4",
                  bus.err, bus.err_cnt, bus.locked, bus.mode_out, bus.step);
      end
      do_ss(8'hFC);
      checks++;
      if (bus.err !== 1'b0 || bus.err_cnt !== 8'h01 || bus.step !== 3'd5) begin
         fails++;
         $display("FAIL skip_next got err=%b err_cnt=%h step=%0d want 0/01/5",
                  bus.err, bus.err_cnt, bus.step);
      end
      idle();
   endtask

   task automatic test_unlock();
      apply_reset();
      do_ss(8'h01);
      do_ss(8'h03);
      do_ss(8'h07);
      do_ss(8'h00);
      checks++;
      if (bus.err !== 1'b1 || bus.locked !== 1'b0 || bus.err_cnt !== 8'h01 ||
          bus.mode_out !== 2'b00 || bus.step !== 3'd2) begin
         fails++;
         $display("FAIL unlock_zero got err=%b locked=%b err_cnt=%h mode=%0d step=%0d want 1/0/01/0/2",
                  bus.err, bus.locked, bus.err_cnt, bus.mode_out, bus.step);
      end
      do_ss(8'hFF);
      checks++;
      if (bus.err !== 1'b0 || bus.locked !== 1'b0 || bus.err_cnt !== 8'h01 || bus.frame_done !== 1'b0) begin
         fails++;
         $display("FAIL unlock_ff got err=%b locked=%b err_cnt=%h fd=%b want 0/0/01/0",
                  bus.err, bus.locked, bus.err_cnt, bus.frame_done);
      end
      do_ss(8'h3F);
      checks++;
      if (bus.locked !== 1'b1 || bus.mode_out !== 2'b00 || bus.step !== 3'd5 || bus.err !== 1'b0) begin
         fails++;
         $display("FAIL unlock_relock got locked=%b mode=%0d step=%0d err=%b want 1/0/5/0",
                  bus.locked, bus.mode_out, bus.step, bus.err);
      end
      idle();
   endtask

   task automatic test_hold_and_async_reset();
      apply_reset();
      do_ss(8'h80);
      do_ss(8'hC0);
      do_ss(8'hE0);
      idle();
      for (int i = 0; i < 20; i++) begin
         bus.led_in = 8'($urandom);
         @(posedge clk);
         #1;
         checks++;
         if (bus.locked !== 1'b1 || bus.mode_out !== 2'b01 || bus.step !== 3'd2 ||
             bus.frame_done !== 1'b0 || bus.mode_chg !== 1'b0 || bus.err !== 1'b0 ||
             bus.err_cnt !== 8'h00 || bus.frame_cnt !== 8'h00) begin
            fails++;
            $display("FAIL hold cyc=%0d got locked=%b mode=%0d step=%0d fd=%b mc=%b err=%b ec=%h fc=%h want 1/1/2/0/0/0/00/00",
                     i, bus.locked, bus.mode_out, bus.step, bus.frame_done, bus.mode_chg,
                     bus.err, bus.err_cnt, bus.frame_cnt);
         end
      end
      do_ss(8'hF0);
      checks++;
      if (bus.step !== 3'd3 || bus.locked !== 1'b1) begin
         fails++;
         $display("FAIL hold_resume got step=%0d locked=%b want 3/1", bus.step, bus.locked);
      end
      @(negedge clk);
      bus.ss = 1'b0;
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({bus.locked, bus.mode_out, bus.step, bus.frame_done, bus.mode_chg, bus.err} !== 9'd0 ||
          bus.err_cnt !== 8'h00 || bus.frame_cnt !== 8'h00) begin
         fails++;
         $display("FAIL async_reset got locked=%b mode=%0d step=%0d ec=%h fc=%h want all 0",
                  bus.locked, bus.mode_out, bus.step, bus.err_cnt, bus.frame_cnt);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_err_saturate();
      int exp_cnt;
      apply_reset();
      do_ss(8'h01);
      for (int i = 1; i <= 300; i++) begin
         do_ss(8'h55);
         exp_cnt = (i > 255) ? 255 : i;
         checks++;
         if (bus.err !== 1'b1 || bus.err_cnt !== 8'(exp_cnt) || bus.locked !== 1'b0) begin
            fails++;
            $display("FAIL sat n=%0d got err=%b err_cnt=%h locked=%b want 1/%h/0",
                     i, bus.err, bus.err_cnt, bus.locked, 8'(exp_cnt));
         end
         do_ss(8'h01);
      end
      idle();
      checks++;
      if (bus.err_cnt !== 8'hFF || bus.locked !== 1'b1) begin
         fails++;
         $display("FAIL sat_final got err_cnt=%h locked=%b want FF/1", bus.err_cnt, bus.locked);
      end
   endtask

   initial begin
      checks     = 0;
      fails      = 0;
      reset      = 1'b0;
      bus.ss     = 1'b0;
      bus.led_in = 8'h00;
      test_reset();
      test_fill_left();
      test_back_to_back();
      test_skip();
      test_unlock();
      test_hold_and_async_reset();
      test_err_saturate();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/led_pattern_checker.md
# led_pattern_checker

Receive-side monitor for the 8-bit LED step-pattern bus. On every step strobe it samples the LED byte and identifies which of the four patterns is running: fill-left, fill-right, converge or diverge. It tracks the step position, reports completed frames and pattern switches, and flags and counts illegal bytes. It sits downstream of the LED pattern generator, on the same clock, as a self-check and status source.

## Interface
- Parameters: none.
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- ss  input  1  step strobe; led_in holds a new pattern byte in this cycle
- led_in  input  8  LED pattern byte under observation
- locked  output  1  1 = tracking a known pattern
- mode_out  output  2  decoded pattern: 00 fill-left, 01 fill-right, 10 converge, 11 diverge
- step  output  3  index of the last accepted byte within its frame
- frame_done  output  1  one-cycle pulse when the final byte (FF) of a frame is accepted
- mode_chg  output  1  one-cycle pulse on a legal switch to a different pattern
- err  output  1  one-cycle pulse on an illegal byte
- err_cnt  output  8  illegal-byte count, saturates at FF
- frame_cnt  output  8  completed-frame count, wraps FF->00

## Operation
- Legal frames, in step order; after the last byte the next frame restarts at step 0:
  - mode 00: 01,03,07,0F,1F,3F,7F,FF (steps 0-7)
  - mode 01: 80,C0,E0,F0,F8,FC,FE,FF (steps 0-7)
  - mode 10: 18,3C,7E,FF (steps 0-3)
  - mode 11: 81,C3,E7,FF (steps 0-3)
- Every byte except FF belongs to exactly one mode. FF is step 7 of modes 00/01 and step 3 of modes 10/11.
- "Unique byte": any legal byte other than FF.
- When ss=0, all state holds and no pulses are raised.
- States: UNLOCKED, LOCKED. Decision is taken on each ss=1 sample with byte B.
- UNLOCKED:
  - B is a unique byte: go to LOCKED; mode_out and step take B's mode and index. No pulse.
  - B is 00, FF or illegal: stay UNLOCKED. No pulse, no count.
- LOCKED, evaluated in priority order:
  1. B equals the expected next byte (step+1, or step 0 after the last step): advance step. If B is FF, pulse frame_done and increment frame_cnt.
  2. B is step 0 of a different mode: switch mode_out, set step=0, pulse mode_chg. frame_cnt is unchanged.
  3. Otherwise (repeat, skip, 00, step 0 of the same mode mid-frame, non-zero step of another mode, illegal byte): pulse err and increment err_cnt (saturating).
     - If B is unique, relock to B's mode and index, staying LOCKED.
     - Otherwise go to UNLOCKED; mode_out and step hold their last values.
- locked = 1 exactly while in LOCKED.

## Timing
- All outputs are registered. A sample taken at edge k is reflected in every output immediately after edge k, so latency is 1 cycle from the ss cycle.
- frame_done, mode_chg and err are high for exactly the one cycle following the sampling edge.
- Back-to-back ss cycles are each evaluated independently. There is no minimum gap between strobes.
- Reset, asserted at any time including mid-frame, forces: locked=0, mode_out=00, step=0, frame_done=0, mode_chg=0, err=0, err_cnt=00, frame_cnt=00. The first sample after release is evaluated in UNLOCKED.
- A 00 byte seen after a generator reset with the checker not reset is an err in LOCKED and is ignored in UNLOCKED.

## Test plan
- Reset, then ss with 01,03,07,0F,1F,3F,7F,FF,01 -> locked=1 after the first byte; step 0..7 then 0; frame_done is a single pulse after FF; frame_cnt=01; mode_out=00; err never asserted.
- Converge stream 18,3C,7E,FF,18 with ss high continuously, then diverge stream 81 -> frame_done once; frame_cnt=01; mode_chg pulses on 81; mode_out=11; step=0.
- Locked in mode 01 at C0, then inject E0,F8 (skip) -> err pulse on F8; err_cnt=01; relock to mode 01 step 4; the next byte FC is accepted with no err.
- Locked in mode 00 at 07, then 00 -> err pulse, locked=0, err_cnt increments; following FF is ignored (no err); following 3F relocks at mode 00 step 5.
- Hold ss=0 for 20 cycles with random led_in -> no output changes. Assert reset mid-frame at step 3 -> all outputs go to reset values without waiting for a clock edge.
- Feed 300 illegal bytes while locked by alternating 55 with a relocking unique byte -> err_cnt saturates at FF and stays there.
